// File: rtl/mips_cpu_state_controller_if.sv
// Control bus between the multicycle sequencer and the datapath/memory side.
// The controller takes the master modport; the datapath takes the slave modport.
interface mips_cpu_state_controller_if;
    logic        waitrequest;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        reg_write_req;
    logic        alu_busy;
    logic        pc_next_zero;

    logic [2:0]  state;
    logic        active;
    logic        ir_load;
    logic        mem_read;
    logic        mem_write;
    logic        addr_sel;
    logic        pc_write;
    logic        reg_write;
    logic        fault;
    logic [31:0] retired;

    modport master (
        input  waitrequest, opcode, funct, reg_write_req, alu_busy, pc_next_zero,
        output state, active, ir_load, mem_read, mem_write, addr_sel, pc_write, reg_write,
        output fault, retired
    );

    modport slave (
        output waitrequest, opcode, funct, reg_write_req, alu_busy, pc_next_zero,
        input  state, active, ir_load, mem_read, mem_write, addr_sel, pc_write, reg_write,
        input  fault, retired
    );
endinterface

// File: rtl/mips_cpu_state_controller.sv
// Multicycle sequencer for the MIPS-compatible core: fetch/decode/exec/mem/writeback,
// waitrequest handshake, long-ALU stall, halt on jump to 0 and memory-hang fault.
module mips_cpu_state_controller #(
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input logic                          clk,
    input logic                          reset,
    mips_cpu_state_controller_if.master  bus
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StFetchWait = 3'd1,
        StDecode    = 3'd2,
        StExec      = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StHalted    = 3'd6,
        StFault     = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic        active_q;
    logic        fault_q;
    logic [31:0] retired_q;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    logic is_load, is_store, is_long;
    logic waiting, timeout;

    always_comb begin
        is_load  = (bus.opcode >= 6'h20) && (bus.opcode <= 6'h26);
        is_store = (bus.opcode == 6'h28) || (bus.opcode == 6'h29) || (bus.opcode == 6'h2B);
        is_long  = (bus.opcode == 6'h00) && (bus.funct[5:2] == 4'b0110);
    end

    // FETCH and FETCH_WAIT form one access, so the count carries across that transition.
    always_comb begin
        waiting = ((state_q == StFetch) || (state_q == StFetchWait) || (state_q == StMem)) &&
                  bus.waitrequest;
        if (!waiting) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == 32'hFFFF_FFFF) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
        timeout = waiting && (WAIT_TIMEOUT != 0) && (wait_cnt_d >= WAIT_TIMEOUT);
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StFault;
        end else begin
            case (state_q)
                StFetch, StFetchWait: state_d = bus.waitrequest ? StFetchWait : StDecode;
                StDecode:             state_d = StExec;
                StExec: begin
                    if (!(is_long && bus.alu_busy)) begin
                        state_d = (is_load || is_store) ? StMem : StWriteback;
                    end
                end
                StMem:                if (!bus.waitrequest) state_d = StWriteback;
                StWriteback:          state_d = bus.pc_next_zero ? StHalted : StFetch;
                default:              state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            active_q   <= 1'b1;
            fault_q    <= 1'b0;
            retired_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= !((state_d == StHalted) || (state_d == StFault));
            wait_cnt_q <= wait_cnt_d;
            if (state_d == StFault) begin
                fault_q <= 1'b1;
            end
            if (state_q == StWriteback) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // Strobes are decoded from the current state so a reset cycle never reaches memory.
    always_comb begin
        bus.ir_load   = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.pc_write  = 1'b0;
        bus.reg_write = 1'b0;
        bus.addr_sel  = (state_q == StMem);
        if (!reset) begin
            unique case (state_q)
                StFetch, StFetchWait: begin
                    bus.mem_read = 1'b1;
                    bus.ir_load  = !bus.waitrequest;
                end
                StMem: begin
                    bus.mem_read  = is_load;
                    bus.mem_write = is_store && !is_load;
                end
                StWriteback: begin
                    bus.pc_write  = 1'b1;
                    bus.reg_write = bus.reg_write_req;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.state   = state_q;
        bus.active  = active_q;
        bus.fault   = fault_q;
        bus.retired = retired_q;
    end

endmodule

// File: tb/tb_mips_cpu_state_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the sequencer.
module tb_mips_cpu_state_controller;

    localparam int unsigned Tmo = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_cpu_state_controller_if bus ();

    mips_cpu_state_controller #(.WAIT_TIMEOUT(Tmo)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;
    bit armed = 1'b0;

    // Model: phase numbers follow the published state encoding.
    int          ph = 0;
    int unsigned cnt = 0;
    logic [31:0] m_ret = 0;
    bit          m_fault = 1'b0;

    logic [2:0]  st_log  [64];
    bit          ir_log  [64];
    bit          rd_log  [64];
    bit          wr_log  [64];
    bit          pcw_log [64];
    bit          rw_log  [64];
    bit          act_log [64];
    bit          flt_log [64];
    logic [31:0] ret_log [64];
    int          logi = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit m_load(input logic [5:0] op);
        return (op >= 6'd32) && (op <= 6'd38);
    endfunction

    function automatic bit m_store(input logic [5:0] op);
        return (op == 6'd40) || (op == 6'd41) || (op == 6'd43);
    endfunction

    function automatic bit m_long(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'd0) && (fn >= 6'd24) && (fn <= 6'd27);
    endfunction

    task automatic compare_model();
        bit ld, st, wr;
        ld = m_load(bus.opcode);
        st = m_store(bus.opcode);
        wr = bus.waitrequest;
        if (armed) begin
            check("state",   32'(bus.state),   32'(ph));
            check("active",  32'(bus.active),  32'((ph != 6) && (ph != 7)));
            check("fault",   32'(bus.fault),   32'(m_fault));
            check("retired", bus.retired,      m_ret);
            check("addr_sel", 32'(bus.addr_sel), 32'(ph == 4));
        end
        check("ir_load",   32'(bus.ir_load),   32'(!rst && (ph <= 1) && !wr));
        check("mem_read",  32'(bus.mem_read),  32'(!rst && ((ph <= 1) || (ph == 4 && ld))));
        check("mem_write", 32'(bus.mem_write), 32'(!rst && ph == 4 && st && !ld));
        check("pc_write",  32'(bus.pc_write),  32'(!rst && ph == 5));
        check("reg_write", 32'(bus.reg_write), 32'(!rst && ph == 5 && bus.reg_write_req));
        check("rd_wr_excl", 32'(bus.mem_read && bus.mem_write), 32'(0));
    endtask

    task automatic advance_model();
        bit stall;
        if (rst) begin
            ph = 0; cnt = 0; m_ret = 0; m_fault = 1'b0;
        end else begin
            stall = ((ph <= 1) || (ph == 4)) && bus.waitrequest;
            if (stall) begin
                if (cnt != 32'hFFFF_FFFF) cnt++;
            end else begin
                cnt = 0;
            end
            if (stall && (Tmo != 0) && (cnt >= Tmo)) begin
                ph = 7;
                m_fault = 1'b1;
            end else if (ph <= 1) begin
                ph = bus.waitrequest ? 1 : 2;
            end else if (ph == 2) begin
                ph = 3;
            end else if (ph == 3) begin
                if (!(m_long(bus.opcode, bus.funct) && bus.alu_busy))
                    ph = (m_load(bus.opcode) || m_store(bus.opcode)) ? 4 : 5;
            end else if (ph == 4) begin
                if (!bus.waitrequest) ph = 5;
            end else if (ph == 5) begin
                m_ret = m_ret + 1;
                ph = bus.pc_next_zero ? 6 : 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
        if (logi < 64) begin
            st_log[logi]  = bus.state;
            ir_log[logi]  = bus.ir_load;
            rd_log[logi]  = bus.mem_read;
            wr_log[logi]  = bus.mem_write;
            pcw_log[logi] = bus.pc_write;
            rw_log[logi]  = bus.reg_write;
            act_log[logi] = bus.active;
            flt_log[logi] = bus.fault;
            ret_log[logi] = bus.retired;
            logi++;
        end
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        armed = 1'b1;
    endtask

    task automatic dir(input int n, input logic [63:0] wrv, input logic [63:0] bsv);
        logi = 0;
        for (int i = 0; i < n; i++) begin
            bus.waitrequest = wrv[i];
            bus.alu_busy    = bsv[i];
            tick();
        end
    endtask

    int exp_addu [5] = '{0, 2, 3, 5, 0};
    int exp_lw   [8] = '{0, 2, 3, 4, 4, 4, 4, 5};
    int exp_sw   [7] = '{0, 1, 1, 2, 3, 4, 5};

    initial begin
        int p, nexec;
        bus.waitrequest   = 1'b0;
        bus.opcode        = 6'h00;
        bus.funct         = 6'h21;
        bus.reg_write_req = 1'b1;
        bus.alu_busy      = 1'b0;
        bus.pc_next_zero  = 1'b0;
        @(posedge clk);
        #1;

        // ADDU
        do_reset();
        dir(5, 64'h0, 64'h0);
        for (int i = 0; i < 5; i++) check("addu_state", 32'(st_log[i]), 32'(exp_addu[i]));
        check("addu_ir_load", 32'(ir_log[0]), 32'(1));
        check("addu_reg_write", 32'(rw_log[3]), 32'(1));
        check("addu_pc_write", 32'(pcw_log[3]), 32'(1));
        check("addu_retired", ret_log[4], 32'd1);

        // LW with three MEM wait cycles
        do_reset();
        bus.opcode = 6'h23;
        dir(8, 64'h38, 64'h0);
        for (int i = 0; i < 8; i++) check("lw_state", 32'(st_log[i]), 32'(exp_lw[i]));
        for (int i = 3; i < 7; i++) check("lw_mem_read", 32'(rd_log[i]), 32'(1));

        // SW with two fetch wait cycles
        do_reset();
        bus.opcode = 6'h2B;
        dir(7, 64'h3, 64'h0);
        for (int i = 0; i < 7; i++) check("sw_state", 32'(st_log[i]), 32'(exp_sw[i]));
        for (int i = 0; i < 7; i++) check("sw_mem_write", 32'(wr_log[i]), 32'(i == 5));

        // DIV with alu_busy for five EXEC cycles, no register write requested
        do_reset();
        bus.opcode = 6'h00;
        bus.funct = 6'h1A;
        bus.reg_write_req = 1'b0;
        dir(9, 64'h0, 64'h7C);
        nexec = 0;
        for (int i = 0; i < 9; i++) if (st_log[i] == 3'd3) nexec++;
        check("div_exec_cycles", 32'(nexec), 32'd6);
        check("div_wb_state", 32'(st_log[8]), 32'd5);
        check("div_reg_write", 32'(rw_log[8]), 32'd0);
        check("div_pc_write", 32'(pcw_log[8]), 32'd1);

        // JR to address 0 halts
        do_reset();
        bus.funct = 6'h08;
        bus.reg_write_req = 1'b1;
        bus.pc_next_zero = 1'b1;
        dir(24, 64'h0, 64'h0);
        check("jr_wb_state", 32'(st_log[3]), 32'd5);
        for (int i = 4; i < 24; i++) begin
            check("halt_state", 32'(st_log[i]), 32'd6);
            check("halt_active", 32'(act_log[i]), 32'd0);
            check("halt_strobes",
                  32'(ir_log[i] | rd_log[i] | wr_log[i] | pcw_log[i] | rw_log[i]), 32'd0);
        end
        bus.pc_next_zero = 1'b0;
        do_reset();
        dir(1, 64'h0, 64'h0);
        check("rst_state", 32'(st_log[0]), 32'd0);
        check("rst_active", 32'(act_log[0]), 32'd1);
        check("rst_retired", ret_log[0], 32'd0);

        // Stuck waitrequest times out
        do_reset();
        dir(9, 64'h1FF, 64'h0);
        check("tmo_fw_state", 32'(st_log[7]), 32'd1);
        check("tmo_state", 32'(st_log[8]), 32'd7);
        check("tmo_fault", 32'(flt_log[8]), 32'd1);
        check("tmo_active", 32'(act_log[8]), 32'd0);
        check("tmo_strobes", 32'(rd_log[8] | ir_log[8]), 32'd0);

        // Reset in the middle of FETCH_WAIT
        do_reset();
        dir(3, 64'h7, 64'h0);
        rst = 1'b1;
        logi = 0;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_strobes", 32'(ir_log[0] | rd_log[0] | wr_log[0] | pcw_log[0] | rw_log[0]),
              32'd0);
        check("midrst_state_before", 32'(st_log[0]), 32'd1);
        check("midrst_state_after", 32'(st_log[1]), 32'd0);

        // Randomized traffic, varying waitrequest density per block
        for (int blk = 0; blk < 40; blk++) begin
            do_reset();
            case (blk % 4)
                0: p = 0;
                1: p = 30;
                2: p = 70;
                default: p = 95;
            endcase
            for (int c = 0; c < 70; c++) begin
                if (ph == 0) begin
                    bus.opcode = ($urandom_range(0, 3) == 0) ? 6'h00
                               : 6'(6'h1E + $urandom_range(0, 14));
                    bus.funct  = 6'(6'h16 + $urandom_range(0, 7));
                end
                bus.waitrequest   = ($urandom_range(0, 99) < p);
                bus.alu_busy      = ($urandom_range(0, 99) < 60);
                bus.pc_next_zero  = ($urandom_range(0, 99) < 6);
                bus.reg_write_req = $urandom_range(0, 1) == 1;
                rst = ($urandom_range(0, 149) == 0);
                tick();
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
